// File: rtl/duty_disp_pkg.sv
// Shared definitions for the duty-cycle 7-segment display block:
// converter FSM states, active-low segment codes and scan digit indices.
package duty_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Active-low segment patterns, bit6=g ... bit0=a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Scan positions; an[i] is driven low while index i is lit
  localparam logic [1:0] IDX_ONES     = 2'd0;
  localparam logic [1:0] IDX_TENS     = 2'd1;
  localparam logic [1:0] IDX_HUNDREDS = 2'd2;
  localparam logic [1:0] IDX_STATUS   = 2'd3;

  // BCD nibble to segment pattern; anything above 9 shows blank
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    code = SEG_BLANK;
    case (digit)
      4'd0: code = SEG_0;
      4'd1: code = SEG_1;
      4'd2: code = SEG_2;
      4'd3: code = SEG_3;
      4'd4: code = SEG_4;
      4'd5: code = SEG_5;
      4'd6: code = SEG_6;
      4'd7: code = SEG_7;
      4'd8: code = SEG_8;
      4'd9: code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double dabble) converter: 8-bit binary to
// three BCD digits. Takes 8 SHIFT cycles plus one DONE cycle per value;
// start is only honoured while IDLE.
module bin2bcd_seq
  import duty_disp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);

  conv_state_t state, state_next;
  logic [19:0] shreg, shreg_next;
  logic [19:0] adj;
  logic [2:0]  shift_cnt, shift_cnt_next;
  logic        busy_q;

  // Next-state logic: load in IDLE, adjust-then-shift in SHIFT, one DONE cycle
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    shift_cnt_next = shift_cnt;
    adj            = shreg;
    if (shreg[11:8]  >= 4'd5) adj[11:8]  = shreg[11:8]  + 4'd3;
    if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_next     = {12'd0, bin_in};
          shift_cnt_next = 3'd0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        shreg_next     = {adj[18:0], 1'b0};
        shift_cnt_next = shift_cnt + 3'd1;
        if (shift_cnt == 3'd7) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, shift register and registered busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      shift_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      shift_cnt <= shift_cnt_next;
      busy_q    <= (state_next != IDLE);
    end
  end

  assign busy    = busy_q;
  assign done    = (state == DONE);
  assign bcd_out = shreg[19:8];

endmodule

// File: rtl/duty_seg_display.sv
// Duty-cycle result to 4-digit multiplexed common-anode 7-segment display.
// Digit 0..2 show ones/tens/hundreds, digit 3 shows F on overflow.
// Optional macro DUTY_LEAD_BLANK_EN blanks leading zeros of hundreds/tens.
module duty_seg_display
  import duty_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  input  logic       carry_in,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic        conv_start;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_bcd;

  logic        ovf_pend;
  logic [3:0]  disp_ones, disp_tens, disp_hund;
  logic        disp_ovf;

  logic [15:0] prescale;
  logic [1:0]  digit_idx;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;

  // A strobe is only taken while the converter is idle; others are dropped
  assign conv_start = value_valid & ~conv_busy;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin_in  (value_in),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  assign busy = conv_busy;
  assign dp   = 1'b1;

  // Hold the overflow flag alongside the value being converted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_pend <= 1'b0;
    else if (conv_start) ovf_pend <= carry_in;
  end

  // Display registers update only on completion so partial results never show
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_ones <= '0;
      disp_tens <= '0;
      disp_hund <= '0;
      disp_ovf  <= 1'b0;
    end else if (conv_done) begin
      disp_ones <= conv_bcd[3:0];
      disp_tens <= conv_bcd[7:4];
      disp_hund <= conv_bcd[11:8];
      disp_ovf  <= ovf_pend;
    end
  end

  // Refresh prescaler; advance the lit digit on every wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale  <= '0;
      digit_idx <= IDX_ONES;
    end else if (prescale == DIV_LAST) begin
      prescale  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescale  <= prescale + 16'd1;
    end
  end

  // Pick the segment pattern and anode enable for the current digit
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = ~(4'b0001 << digit_idx);
    case (digit_idx)
      IDX_ONES: seg_next = seg_decode(disp_ones);
`ifdef DUTY_LEAD_BLANK_EN
      IDX_TENS:     seg_next = ((disp_hund == 4'd0) && (disp_tens == 4'd0)) ?
                               SEG_BLANK : seg_decode(disp_tens);
      IDX_HUNDREDS: seg_next = (disp_hund == 4'd0) ? SEG_BLANK : seg_decode(disp_hund);
`else
      IDX_TENS:     seg_next = seg_decode(disp_tens);
      IDX_HUNDREDS: seg_next = seg_decode(disp_hund);
`endif
      IDX_STATUS:   seg_next = disp_ovf ? SEG_F : SEG_BLANK;
      default:      seg_next = SEG_BLANK;
    endcase
  end

  // Register seg and an together so they always switch on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1110;
      seg <= SEG_0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_duty_seg_display.sv
// Scoreboard bench for duty_seg_display with REFRESH_DIV=4.
// Stimulus pushes hand-computed digit patterns; the monitor pops one entry
// per completed conversion and checks a full scan round of the display.
module tb_duty_seg_display;

  localparam int RD = 4;

`ifdef DUTY_LEAD_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif

  typedef struct packed {
    logic [6:0] ones;
    logic [6:0] tens;
    logic [6:0] hund;
    logic [6:0] stat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value_in = '0;
  logic       value_valid = 1'b0;
  logic       carry_in = 1'b0;
  logic       busy;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  duty_seg_display #(.REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .carry_in    (carry_in),
    .busy        (busy),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop if something hangs
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic pulseStrobe(input logic [7:0] v, input logic c);
    @(negedge clk);
    value_in    = v;
    carry_in    = c;
    value_valid = 1'b1;
    @(posedge clk);
    #1;
    value_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic c, input exp_t e);
    int busy_cnt;
    exp_q.push_back(e);
    pulseStrobe(v, c);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("busy_cycles", 32'(busy_cnt), 32'd9);
    repeat (30) @(posedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_an"},   32'(an),   32'b1110);
    checkOutput({tag, "_seg"},  32'(seg),  32'b1000000);
    checkOutput({tag, "_dp"},   32'(dp),   32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: after each normal conversion completes, collect one scan round
  initial begin
    logic [6:0] got [4];
    logic [3:0] seen;
    exp_t       e;
    forever begin
      @(negedge busy);
      if (reset) continue;
      repeat (2) @(posedge clk);
      seen = '0;
      for (int c = 0; c < 4 * RD + 4; c++) begin
        @(negedge clk);
        case (an)
          4'b1110: begin got[0] = seg; seen[0] = 1'b1; end
          4'b1101: begin got[1] = seg; seen[1] = 1'b1; end
          4'b1011: begin got[2] = seg; seen[2] = 1'b1; end
          4'b0111: begin got[3] = seg; seen[3] = 1'b1; end
          default: ;
        endcase
      end
      checkOutput("dp", 32'(dp), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_conversion: got digits %b %b %b %b expected none",
                 got[2], got[1], got[0], got[3]);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ones",     32'({seen[0], got[0]}), 32'({1'b1, e.ones}));
        checkOutput("tens",     32'({seen[1], got[1]}), 32'({1'b1, e.tens}));
        checkOutput("hundreds", 32'({seen[2], got[2]}), 32'({1'b1, e.hund}));
        checkOutput("status",   32'({seen[3], got[3]}), 32'({1'b1, e.stat}));
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // 173 -> 1/7/3, no overflow
    applyStimulus(8'd173, 1'b0, '{ones: 7'b0110000, tens: 7'b1111000, hund: 7'b1111001, stat: 7'b1111111});
    // 255 with carry -> 2/5/5 and F
    applyStimulus(8'd255, 1'b1, '{ones: 7'b0010010, tens: 7'b0010010, hund: 7'b0100100, stat: 7'b0001110});
    // 5 -> leading zeros shown or blanked depending on build
    applyStimulus(8'd5,   1'b0, '{ones: 7'b0010010, tens: LZ, hund: LZ, stat: 7'b1111111});
    // 90 -> hundreds zero, tens nine
    applyStimulus(8'd90,  1'b0, '{ones: 7'b1000000, tens: 7'b0010000, hund: LZ, stat: 7'b1111111});

    // 100 then 42 three edges later: the 42 must be dropped
    exp_q.push_back('{ones: 7'b1000000, tens: 7'b1000000, hund: 7'b1111001, stat: 7'b1111111});
    pulseStrobe(8'd100, 1'b0);
    repeat (2) @(posedge clk);
    pulseStrobe(8'd42, 1'b0);
    repeat (45) @(posedge clk);

    // Abort a 200 conversion during its 4th shift cycle
    pulseStrobe(8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 64 after the abort -> 0/6/4
    applyStimulus(8'd64, 1'b0, '{ones: 7'b0011001, tens: 7'b0000010, hund: LZ, stat: 7'b1111111});

    repeat (10) @(posedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
